dcache_refill_buffer: RTL



---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_refill_buffer_if.sv | 46 ++++
 rtl/dcache_refill_merge.sv | 32 +++
 rtl/dcache_refill_buffer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants and state type for the D-cache refill buffer.
package dcache_pkg;

  localparam int LINE_BITS  = 256;
  localparam int BEAT_BITS  = 64;
  localparam int LINE_BEATS = LINE_BITS / BEAT_BITS;
  localparam int LINE_LANES = LINE_BITS / 8;
  localparam int BEAT_LANES = BEAT_BITS / 8;

  localparam logic [LINE_LANES-1:0] FULL_LINE_BE = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE
  } refill_state_e;

endpackage

// File: rtl/dcache_refill_buffer_if.sv
// Request, bus-beat, store-probe, data-array and completion signals of the refill buffer.
interface dcache_refill_buffer_if #(
  parameter int DATA = dcache_pkg::LINE_BITS,
  parameter int ADDR = 8,
  parameter int BEAT = dcache_pkg::BEAT_BITS
);

  logic                req_valid;
  logic                req_ready;
  logic [ADDR-1:0]     req_index;
  logic [1:0]          req_crit;
  logic                beat_valid;
  logic                beat_ready;
  logic [BEAT-1:0]     beat_data;
  logic                beat_err;
  logic                st_valid;
  logic [ADDR-1:0]     st_index;
  logic [DATA-1:0]     st_data;
  logic [DATA/8-1:0]   st_byte_en;
  logic                st_hit;
  logic                arr_chip_en;
  logic                arr_write_en;
  logic [ADDR-1:0]     arr_addr;
  logic [DATA-1:0]     arr_write_data;
  logic [DATA/8-1:0]   arr_byte_chose;
  logic                arr_grant;
  logic                crit_valid;
  logic [BEAT-1:0]     crit_data;
  logic                done_valid;
  logic                done_err;

  modport master (
    output req_valid, req_index, req_crit, beat_valid, beat_data, beat_err,
           st_valid, st_index, st_data, st_byte_en, arr_grant,
    input  req_ready, beat_ready, st_hit, arr_chip_en, arr_write_en, arr_addr,
           arr_write_data, arr_byte_chose, crit_valid, crit_data, done_valid, done_err
  );

  modport slave (
    input  req_valid, req_index, req_crit, beat_valid, beat_data, beat_err,
           st_valid, st_index, st_data, st_byte_en, arr_grant,
    output req_ready, beat_ready, st_hit, arr_chip_en, arr_write_en, arr_addr,
           arr_write_data, arr_byte_chose, crit_valid, crit_data, done_valid, done_err
  );

endinterface

// File: rtl/dcache_refill_merge.sv
// Byte-wise merge of one line slot: a store byte always wins, a bus beat only fills bytes no store has claimed.
module dcache_refill_merge
  import dcache_pkg::*;
#(
  parameter int BEAT  = BEAT_BITS,
  parameter int LANES = BEAT_LANES
) (
  input  logic [BEAT-1:0]  slot_data,
  input  logic [LANES-1:0] mask,
  input  logic             beat_we,
  input  logic [BEAT-1:0]  beat_data,
  input  logic             st_we,
  input  logic [BEAT-1:0]  st_data,
  input  logic [LANES-1:0] st_byte_en,
  output logic [BEAT-1:0]  merged_data,
  output logic [LANES-1:0] merged_mask
);

  always_comb begin
    merged_data = slot_data;
    merged_mask = mask;
    for (int b = 0; b < LANES; b++) begin
      if (st_we && st_byte_en[b]) begin
        merged_data[b*8 +: 8] = st_data[b*8 +: 8];
        merged_mask[b]        = 1'b1;
      end else if (beat_we && !mask[b]) begin
        merged_data[b*8 +: 8] = beat_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_refill_buffer.sv
// D-cache line-fill buffer: gathers four wrap-ordered beats, merges in-flight stores, writes the full line.
// Optional critical-beat forwarding is enabled by defining DCACHE_REFILL_CRIT_FWD_EN.
module dcache_refill_buffer
  import dcache_pkg::*;
#(
  parameter int DATA = LINE_BITS,
  parameter int ADDR = 8,
  parameter int BEAT = BEAT_BITS
) (
  input logic                    clk,
  input logic                    rst,
  dcache_refill_buffer_if.slave  bus
);

  localparam int BEATS      = DATA / BEAT;
  localparam int LANES      = DATA / 8;
  localparam int SLOT_LANES = BEAT / 8;

  refill_state_e    state;
  logic [ADDR-1:0]  index;
  logic [1:0]       ptr;
  logic [1:0]       cnt;
  logic             err;
  logic [DATA-1:0]  line;
  logic [LANES-1:0] mask;
  logic             req_ready_q;
  logic             beat_ready_q;
  logic             arr_en_q;
  logic             err_done_q;

  logic [DATA-1:0]  line_next;
  logic [LANES-1:0] mask_next;
  logic             req_acc;
  logic             beat_acc;
  logic             grant;
  logic             st_hit;

  assign req_acc  = bus.req_valid & req_ready_q;
  assign beat_acc = bus.beat_valid & beat_ready_q;
  assign grant    = arr_en_q & bus.arr_grant;
  // Stores stop merging in the grant cycle so the written line matches what the array captures.
  assign st_hit   = bus.st_valid & (bus.st_index == index) &
                    ((state == ST_FILL) | ((state == ST_WRITE) & ~grant));

  for (genvar k = 0; k < BEATS; k++) begin : g_slot
    dcache_refill_merge #(.BEAT(BEAT), .LANES(SLOT_LANES)) u_merge (
      .slot_data   (line[k*BEAT +: BEAT]),
      .mask        (mask[k*SLOT_LANES +: SLOT_LANES]),
      .beat_we     (beat_acc && (ptr == 2'(k))),
      .beat_data   (bus.beat_data),
      .st_we       (st_hit),
      .st_data     (bus.st_data[k*BEAT +: BEAT]),
      .st_byte_en  (bus.st_byte_en[k*SLOT_LANES +: SLOT_LANES]),
      .merged_data (line_next[k*BEAT +: BEAT]),
      .merged_mask (mask_next[k*SLOT_LANES +: SLOT_LANES])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      index        <= '0;
      ptr          <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      line         <= '0;
      mask         <= '0;
      req_ready_q  <= 1'b1;
      beat_ready_q <= 1'b0;
      arr_en_q     <= 1'b0;
      err_done_q   <= 1'b0;
    end else begin
      line       <= line_next;
      mask       <= mask_next;
      err_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_acc) begin
            index        <= bus.req_index;
            ptr          <= bus.req_crit;
            cnt          <= '0;
            err          <= 1'b0;
            mask         <= '0;
            req_ready_q  <= 1'b0;
            beat_ready_q <= 1'b1;
            state        <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (beat_acc) begin
            ptr <= ptr + 2'd1;
            cnt <= cnt + 2'd1;
            err <= err | bus.beat_err;
            if (cnt == 2'(BEATS - 1)) begin
              beat_ready_q <= 1'b0;
              state        <= ST_WRITE;
              if (err | bus.beat_err) begin
                err_done_q <= 1'b1;
              end else begin
                arr_en_q <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          // An errored line is reported once and dropped without touching the array.
          if (err || grant) begin
            arr_en_q    <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.beat_ready     = beat_ready_q;
  assign bus.st_hit         = st_hit;
  assign bus.arr_chip_en    = arr_en_q;
  assign bus.arr_write_en   = arr_en_q;
  assign bus.arr_addr       = arr_en_q ? index : '0;
  assign bus.arr_write_data = arr_en_q ? line : '0;
  assign bus.arr_byte_chose = arr_en_q ? FULL_LINE_BE : '0;
  assign bus.done_valid     = grant | err_done_q;
  assign bus.done_err       = err_done_q;

`ifdef DCACHE_REFILL_CRIT_FWD_EN
  logic            crit_valid_q;
  logic [BEAT-1:0] crit_data_q;
  logic            fwd;

  assign fwd = beat_acc & (cnt == 2'd0) & ~bus.beat_err;

  // The forwarded beat is taken after merging so a store already in the slot is visible to the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= fwd;
      crit_data_q  <= fwd ? line_next[int'(ptr)*BEAT +: BEAT] : '0;
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif

endmodule
